// File: rtl/dmem_arbiter.sv
// Data BRAM arbiter: CPU load/store port vs. burst accelerator port; CPU wins each cycle by default.
// Latency: BRAM access issued combinationally in the grant cycle, read data one cycle later.
// Backpressure: cpu_stall holds the CPU; preempted bursts pause in place. `define ACC_PRIO_EN locks the BRAM to a running burst.
module dmem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_en,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              acc_req,
   input  logic              acc_wr,
   input  logic [ADDR_W-1:0] acc_addr,
   input  logic [LEN_W-1:0]  acc_len,
   input  logic [DATA_W-1:0] acc_wdata,
   output logic              acc_wack,
   output logic [DATA_W-1:0] acc_rdata,
   output logic              acc_rvalid,
   output logic              acc_busy,
   output logic              acc_done,
   output logic              bram_en,
   output logic              bram_wr,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_wdata,
   input  logic [DATA_W-1:0] bram_rdata
);

   typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;

   state_t            state_q;
   logic [LEN_W-1:0]  idx_q;
   logic [LEN_W-1:0]  len_q;
   logic [ADDR_W-1:0] base_q;
   logic              wr_q;
   logic              rvalid_q;

   logic              cpu_grant;
   logic              acc_grant;
   logic              last_beat;
   logic [ADDR_W-1:0] beat_addr;

`ifdef ACC_PRIO_EN
   // A running burst (BURST and FLUSH) locks the CPU out entirely.
   assign cpu_grant = cpu_en & (state_q == IDLE);
   assign acc_grant = (state_q == BURST);
`else
   assign cpu_grant = cpu_en;
   assign acc_grant = (state_q == BURST) & ~cpu_en;
`endif

   assign last_beat = (idx_q == len_q - LEN_W'(1));
   // Address wraps naturally at 2^ADDR_W.
   assign beat_addr = base_q + ADDR_W'(idx_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         len_q    <= '0;
         base_q   <= '0;
         wr_q     <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= acc_grant & ~wr_q;
         case (state_q)
            IDLE: begin
               if (acc_req) begin
                  wr_q    <= acc_wr;
                  base_q  <= acc_addr;
                  len_q   <= acc_len;
                  idx_q   <= '0;
                  state_q <= (acc_len == '0) ? FLUSH : BURST;
               end
            end
            BURST: begin
               if (acc_grant) begin
                  idx_q <= idx_q + LEN_W'(1);
                  if (last_beat) state_q <= FLUSH;
               end
            end
            FLUSH:   state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      bram_en    = 1'b0;
      bram_wr    = 1'b0;
      bram_addr  = '0;
      bram_wdata = '0;
      if (cpu_grant) begin
         bram_en    = 1'b1;
         bram_wr    = cpu_wr;
         bram_addr  = cpu_addr;
         bram_wdata = cpu_wdata;
      end else if (acc_grant) begin
         bram_en    = 1'b1;
         bram_wr    = wr_q;
         bram_addr  = beat_addr;
         bram_wdata = acc_wdata;
      end
   end

   assign cpu_stall  = cpu_en & ~cpu_grant;
   assign acc_wack   = acc_grant & wr_q;
   assign acc_rvalid = rvalid_q;
   assign acc_busy   = (state_q != IDLE);
   assign acc_done   = (state_q == FLUSH);
   assign cpu_rdata  = bram_rdata;
   assign acc_rdata  = bram_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural BRAM, scoreboard queues for bus beats and read data.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_en, cpu_wr;
   logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        acc_req, acc_wr;
   logic [15:0] acc_addr, acc_wdata, acc_rdata;
   logic [7:0]  acc_len;
   logic        acc_wack, acc_rvalid, acc_busy, acc_done;
   logic        bram_en, bram_wr;
   logic [15:0] bram_addr, bram_wdata;
   logic [15:0] bram_rdata;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .LEN_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_en(cpu_en), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .acc_req(acc_req), .acc_wr(acc_wr), .acc_addr(acc_addr), .acc_len(acc_len),
      .acc_wdata(acc_wdata), .acc_wack(acc_wack), .acc_rdata(acc_rdata),
      .acc_rvalid(acc_rvalid), .acc_busy(acc_busy), .acc_done(acc_done),
      .bram_en(bram_en), .bram_wr(bram_wr), .bram_addr(bram_addr),
      .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
   );

   function automatic logic [15:0] pat(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   // Behavioural BRAM: unwritten words read back as pat(addr).
   logic [15:0] mem [int];
   always @(posedge clk) begin
      if (bram_en) begin
         if (bram_wr) mem[int'(bram_addr)] = bram_wdata;
         else bram_rdata <= mem.exists(int'(bram_addr)) ? mem[int'(bram_addr)] : pat(bram_addr);
      end
   end

   typedef struct packed {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
   } bus_t;

   bus_t        exp_bus[$];
   logic [15:0] exp_rd[$];
   logic [15:0] exp_cpu[$];

   int   n_assert = 0, n_fail = 0;
   int   cyc = 0, req_cyc = 0, done_cnt = 0, done_cyc = 0;
   int   wack_cnt = 0, rv_cnt = 0, stall_cnt = 0, wptr = 0;
   int   s0, w0, r0, d0;
   logic cpu_ld_pend = 1'b0;
   logic [15:0] wbase = 16'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ctrl"}, 32'({acc_busy, acc_done, acc_rvalid, acc_wack, cpu_stall, bram_en, bram_wr}), 32'h0);
      check({tag, "_addr"}, 32'(bram_addr), 32'h0);
      check({tag, "_wdata"}, 32'(bram_wdata), 32'h0);
   endtask

   // Per-cycle monitor: pops the scoreboard whenever the DUT produces something.
   task automatic mon();
      bus_t        e;
      logic [15:0] d;
      if (cpu_ld_pend) begin
         check("cpu_rd_expected", 32'(exp_cpu.size() != 0), 32'h1);
         if (exp_cpu.size() != 0) begin
            d = exp_cpu.pop_front();
            check("cpu_rdata", 32'(cpu_rdata), 32'(d));
         end
      end
      cpu_ld_pend = cpu_en & ~cpu_wr & ~cpu_stall;
      if (bram_en) begin
         check("bram_beat_expected", 32'(exp_bus.size() != 0), 32'h1);
         if (exp_bus.size() != 0) begin
            e = exp_bus.pop_front();
            check("bram_wr", 32'(bram_wr), 32'(e.wr));
            check("bram_addr", 32'(bram_addr), 32'(e.addr));
            if (e.wr) check("bram_wdata", 32'(bram_wdata), 32'(e.wdata));
         end
      end
      if (acc_rvalid) begin
         rv_cnt++;
         check("acc_rvalid_expected", 32'(exp_rd.size() != 0), 32'h1);
         if (exp_rd.size() != 0) begin
            d = exp_rd.pop_front();
            check("acc_rdata", 32'(acc_rdata), 32'(d));
         end
      end
      if (acc_wack) begin
         wack_cnt++;
         wptr++;
      end
      if (acc_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (cpu_stall) stall_cnt++;
   endtask

   task automatic step();
      acc_wdata = wbase + 16'(wptr);
      #2;
      mon();
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_until_done(input int budget, input string tag);
      int d_start;
      d_start = done_cnt;
      for (int i = 0; i < budget; i++) begin
         step();
         if (done_cnt != d_start) break;
      end
      check(tag, 32'(done_cnt - d_start), 32'h1);
   endtask

   task automatic start_burst(input logic wr, input logic [15:0] base, input logic [7:0] len);
      acc_req  = 1'b1;
      acc_wr   = wr;
      acc_addr = base;
      acc_len  = len;
      req_cyc  = cyc;
      step();
      acc_req  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      cpu_en = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      acc_req = 1'b0; acc_wr = 1'b0; acc_addr = '0; acc_len = '0; acc_wdata = '0;
      #2;
      check_idle("reset");
      @(negedge clk);
      step();
      rst_n = 1'b1;
      step();

      // CPU store then load at 0x0010
      s0 = stall_cnt;
      exp_bus.push_back('{1'b1, 16'h0010, 16'hBEEF});
      cpu_en = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
      step();
      exp_bus.push_back('{1'b0, 16'h0010, 16'h0});
      exp_cpu.push_back(16'hBEEF);
      cpu_wr = 1'b0;
      step();
      cpu_en = 1'b0;
      step();
      check("cpu_no_stall", 32'(stall_cnt - s0), 32'h0);
      check("cpu_rd_drained", 32'(exp_cpu.size()), 32'h0);

      // Uncontended read burst 0x0100, len 4
      for (int i = 0; i < 4; i++) begin
         exp_bus.push_back('{1'b0, 16'h0100 + 16'(i), 16'h0});
         exp_rd.push_back(pat(16'h0100 + 16'(i)));
      end
      r0 = rv_cnt;
      start_burst(1'b0, 16'h0100, 8'd4);
      run_until_done(20, "rd_done");
      check("rd_latency", 32'(done_cyc - req_cyc), 32'd5);
      check("rd_rvalids", 32'(rv_cnt - r0), 32'd4);
      step();
      check("rd_busy_clear", 32'(acc_busy), 32'h0);

`ifndef ACC_PRIO_EN
      // Write burst len 3, CPU load collides on beat 2
      wbase = 16'hA000; wptr = 0;
      w0 = wack_cnt; s0 = stall_cnt;
      exp_bus.push_back('{1'b1, 16'h0200, 16'hA000});
      exp_bus.push_back('{1'b0, 16'h0010, 16'h0});
      exp_bus.push_back('{1'b1, 16'h0201, 16'hA001});
      exp_bus.push_back('{1'b1, 16'h0202, 16'hA002});
      exp_cpu.push_back(16'hBEEF);
      start_burst(1'b1, 16'h0200, 8'd3);
      step();
      cpu_en = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0010;
      step();
      cpu_en = 1'b0;
      run_until_done(20, "wr_done");
      check("wr_latency", 32'(done_cyc - req_cyc), 32'd5);
      check("wr_wacks", 32'(wack_cnt - w0), 32'd3);
      check("wr_cpu_no_stall", 32'(stall_cnt - s0), 32'h0);
      step();
      exp_bus.push_back('{1'b0, 16'h0201, 16'h0});
      exp_cpu.push_back(16'hA001);
      cpu_en = 1'b1; cpu_addr = 16'h0201;
      step();
      cpu_en = 1'b0;
      step();
`endif

      // Address wrap at 0xFFFE
      for (int i = 0; i < 4; i++) begin
         exp_bus.push_back('{1'b0, 16'hFFFE + 16'(i), 16'h0});
         exp_rd.push_back(pat(16'hFFFE + 16'(i)));
      end
      start_burst(1'b0, 16'hFFFE, 8'd4);
      run_until_done(20, "wrap_done");
      check("wrap_latency", 32'(done_cyc - req_cyc), 32'd5);
      step();

      // Zero-length burst: no BRAM access
      start_burst(1'b0, 16'h0500, 8'd0);
      run_until_done(5, "zero_done");
      check("zero_latency", 32'(done_cyc - req_cyc), 32'd1);
      step();

      // Reset during beat 2 of 8
      exp_bus.push_back('{1'b0, 16'h0300, 16'h0});
      start_burst(1'b0, 16'h0300, 8'd8);
      step();
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      check_idle("midreset");
      step();
      step();
      rst_n = 1'b1;
      repeat (10) step();
      check("midreset_no_done", 32'(done_cnt - d0), 32'h0);
      check("midreset_busy", 32'(acc_busy), 32'h0);

`ifdef ACC_PRIO_EN
      // Burst owns the BRAM; CPU load waits until after FLUSH
      for (int i = 0; i < 4; i++) begin
         exp_bus.push_back('{1'b0, 16'h0400 + 16'(i), 16'h0});
         exp_rd.push_back(pat(16'h0400 + 16'(i)));
      end
      exp_bus.push_back('{1'b0, 16'h0010, 16'h0});
      exp_cpu.push_back(16'hBEEF);
      s0 = stall_cnt;
      start_burst(1'b0, 16'h0400, 8'd4);
      step();
      cpu_en = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0010;
      run_until_done(20, "prio_done");
      check("prio_latency", 32'(done_cyc - req_cyc), 32'd5);
      step();
      cpu_en = 1'b0;
      step();
      check("prio_stall_cycles", 32'(stall_cnt - s0), 32'd4);
`endif

      check("bus_queue_empty", 32'(exp_bus.size()), 32'h0);
      check("rd_queue_empty", 32'(exp_rd.size()), 32'h0);
      check("cpu_queue_empty", 32'(exp_cpu.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
